enigma_feeder: RTL and testbench

Upstream feeder for the `enigma` encoder core. Accepts a raw ASCII byte stream (e.g. from the UART receiver) and filters out non-letters. Converts letters to the core's 1..26 letter code and buffers them in a FIFO. Issues them one at a time over the core's `data_valid_in`/`ready` handshake, which takes single-cycle valid pulses. Sits between the byte-source stage and `enigma`.

---
 rtl/enigma_feeder.sv | 166 ++++++++++++++++
 tb/tb_enigma_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_feeder.sv
// ASCII-to-letter-code feeder for the enigma core: filters bytes, queues codes, issues single-cycle pulses.
// Optional: define ENIGMA_FEEDER_LOWERCASE_EN to accept lowercase letters as well.
module enigma_feeder #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     flush_in,
  input  logic                     ascii_valid_in,
  input  logic [7:0]               ascii_in,
  output logic                     ascii_ready_out,
  input  logic                     enc_ready_in,
  output logic                     enc_valid_out,
  output logic [4:0]               enc_data_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out,
  output logic [CNT_W-1:0]         letter_count_out,
  output logic [CNT_W-1:0]         drop_count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL_C    = CW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t            state_r;
  logic [4:0]        mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CNT_W-1:0]  letter_cnt_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic              valid_r;
  logic [4:0]        data_r;

  logic [5:0]        dec_s;
  logic              accept_s;
  logic              push_s;
  logic              drop_s;
  logic              pop_s;

  // Bit 5 flags a letter, bits 4:0 carry its 1..26 code.
  function automatic logic [5:0] decode_byte(input logic [7:0] b);
    logic [5:0] r;
    r = 6'd0;
    if (b >= 8'h41 && b <= 8'h5A) begin
      r = {1'b1, 5'(b - 8'h40)};
    end
`ifdef ENIGMA_FEEDER_LOWERCASE_EN
    else if (b >= 8'h61 && b <= 8'h7A) begin
      r = {1'b1, 5'(b - 8'h60)};
    end
`endif
    else begin
      r = 6'd0;
    end
    return r;
  endfunction

  assign ascii_ready_out  = (count_r < FULL_C);
  assign enc_valid_out    = valid_r;
  assign enc_data_out     = data_r;
  assign fifo_count_out   = count_r;
  assign letter_count_out = letter_cnt_r;
  assign drop_count_out   = drop_cnt_r;

  // Flush swallows any byte arriving in the same cycle and blocks the pop.
  always_comb begin
    dec_s    = decode_byte(ascii_in);
    accept_s = ascii_valid_in && ascii_ready_out;
    push_s   = accept_s && dec_s[5] && !flush_in;
    drop_s   = accept_s && !dec_s[5] && !flush_in;
    pop_s    = (state_r == IDLE) && (count_r != {CW{1'b0}}) && enc_ready_in && !flush_in;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 5'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_in) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= dec_s[4:0];
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating statistics; flush deliberately leaves them alone.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      letter_cnt_r <= {CNT_W{1'b0}};
      drop_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (pop_s && letter_cnt_r != CNT_MAX_C) begin
        letter_cnt_r <= letter_cnt_r + CNT_W'(1);
      end
      if (drop_s && drop_cnt_r != CNT_MAX_C) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end
  end

  // Issue FSM: one pulse per core transaction, re-arm only after ready has gone low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      data_r  <= 5'd0;
    end else if (flush_in) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            data_r  <= mem_r[rd_ptr_r];
            valid_r <= 1'b1;
            state_r <= ISSUE;
          end else begin
            valid_r <= 1'b0;
          end
        end
        ISSUE: begin
          valid_r <= 1'b0;
          state_r <= WAIT_LOW;
        end
        WAIT_LOW: begin
          valid_r <= 1'b0;
          if (!enc_ready_in) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_LOW;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_feeder.sv
// Scoreboard bench for enigma_feeder with a simple enigma-core ready model.
module tb_enigma_feeder;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              ascii_valid;
  logic [7:0]        ascii;
  logic              ascii_ready;
  logic              enc_ready;
  logic              enc_valid;
  logic [4:0]        enc_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]  letter_count;
  logic [CNT_W-1:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_letters = 0;
  int exp_drop = 0;
  bit force_low = 1'b0;
  int low_cnt = 0;
  bit pend = 1'b0;
  bit prev_valid = 1'b0;
  bit prev_ready = 1'b0;

  enigma_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .flush_in         (flush),
    .ascii_valid_in   (ascii_valid),
    .ascii_in         (ascii),
    .ascii_ready_out  (ascii_ready),
    .enc_ready_in     (enc_ready),
    .enc_valid_out    (enc_valid),
    .enc_data_out     (enc_data),
    .fifo_count_out   (fifo_count),
    .letter_count_out (letter_count),
    .drop_count_out   (drop_count)
  );

  always #5 clk = ~clk;

  // Monitor plus core model: the core samples a pulse, then holds ready low for 8 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      enc_ready  = !force_low;
      low_cnt    = 0;
      pend       = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (enc_valid) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL back_to_back_pulse actual=1 expected=0");
        end
        checks++;
        if (!prev_ready) begin
          errors++;
          $display("FAIL pulse_while_ready_low actual=0 expected=1");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual=%0d expected=none", enc_data);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (int'(enc_data) != e) begin
            errors++;
            $display("FAIL pulse_code actual=%0d expected=%0d", enc_data, e);
          end
        end
      end
      if (pend) begin
        pend    = 1'b0;
        low_cnt = 8;
      end
      if (enc_valid) pend = 1'b1;
      if (low_cnt > 0) begin
        low_cnt--;
        enc_ready = 1'b0;
      end else begin
        enc_ready = !force_low;
      end
      prev_valid = enc_valid;
      prev_ready = enc_ready;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Enter and leave at a negedge; holds the byte until the DUT accepts it.
  task automatic send(input logic [7:0] b, input int code, input bit issue);
    int n;
    n = 0;
    ascii       = b;
    ascii_valid = 1'b1;
    if (issue) begin
      exp_q.push_back(code);
      exp_letters++;
    end
    if (code == 0) exp_drop++;
    while (!ascii_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled expected=accept byte=%h", b);
    end
    @(negedge clk);
    ascii_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s_drain actual=%0d_pending expected=0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    rst_n = 1'b0;
    flush = 1'b0;
    ascii_valid = 1'b0;
    ascii = 8'h00;
    enc_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ascii_ready", int'(ascii_ready), 1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_enc_valid", int'(enc_valid), 0);
    chk("rst_letters", int'(letter_count), 0);
    chk("rst_drops", int'(drop_count), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 'A': exact edge timing
    ascii = 8'h41;
    ascii_valid = 1'b1;
    exp_q.push_back(1);
    exp_letters++;
    @(posedge clk); #1;
    chk("a_count_after_e0", int'(fifo_count), 1);
    chk("a_valid_after_e0", int'(enc_valid), 0);
    @(negedge clk);
    ascii_valid = 1'b0;
    @(posedge clk); #1;
    chk("a_valid_after_e1", int'(enc_valid), 1);
    chk("a_data_after_e1", int'(enc_data), 1);
    chk("a_count_after_e1", int'(fifo_count), 0);
    @(posedge clk); #1;
    chk("a_valid_after_e2", int'(enc_valid), 0);
    chk("a_letters", int'(letter_count), 1);
    @(negedge clk);
    wait_drain(60, "a");
    chk("a_data_hold", int'(enc_data), 1);

    // "Z 9"
    send(8'h5A, 26, 1'b1);
    send(8'h20, 0, 1'b0);
    send(8'h39, 0, 1'b0);
    wait_drain(100, "z9");
    chk("z9_drops", int'(drop_count), exp_drop);
    chk("z9_letters", int'(letter_count), exp_letters);

    // "HELLO" at core rate
    send(8'h48, 8, 1'b1);
    send(8'h45, 5, 1'b1);
    send(8'h4C, 12, 1'b1);
    send(8'h4C, 12, 1'b1);
    send(8'h4F, 15, 1'b1);
    wait_drain(300, "hello");
    chk("hello_letters", int'(letter_count), exp_letters);
    chk("hello_drops", int'(drop_count), exp_drop);

    // Fill past DEPTH with the core stalled
    force_low = 1'b1;
    repeat (2) @(negedge clk);
    idx = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      bit acc;
      ascii = 8'(8'h41 + idx);
      ascii_valid = 1'b1;
      acc = ascii_ready;
      @(negedge clk);
      if (acc) begin
        exp_q.push_back(idx + 1);
        exp_letters++;
        idx++;
      end
    end
    chk("full_accepts", idx, DEPTH);
    chk("full_ascii_ready", int'(ascii_ready), 0);
    chk("full_count", int'(fifo_count), DEPTH);
    ascii_valid = 1'b0;
    chk("full_drops", int'(drop_count), exp_drop);
    force_low = 1'b0;
    wait_drain(800, "full");
    chk("full_letters", int'(letter_count), exp_letters);

    // Flush with a simultaneous non-letter push
    force_low = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) send(8'(8'h44 + k), 4 + k, 1'b0);
    chk("flush_prefill", int'(fifo_count), 5);
    flush = 1'b1;
    ascii = 8'h20;
    ascii_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ascii_valid = 1'b0;
    chk("flush_count", int'(fifo_count), 0);
    chk("flush_drops", int'(drop_count), exp_drop);
    chk("flush_valid", int'(enc_valid), 0);
    force_low = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_count_later", int'(fifo_count), 0);
    chk("flush_letters", int'(letter_count), exp_letters);

    // Lowercase 'q'
`ifdef ENIGMA_FEEDER_LOWERCASE_EN
    send(8'h71, 17, 1'b1);
`else
    send(8'h71, 0, 1'b0);
`endif
    wait_drain(100, "q");
    chk("q_drops", int'(drop_count), exp_drop);
    chk("q_letters", int'(letter_count), exp_letters);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
